// File: rtl/random_lcg_if.sv
// Request/result bundle between the game FSM (master) and the LCG (slave).
// The RANDOM_LCG_DIST_EN macro adds the pre-decoded dist/layout/color fields.
interface random_lcg_if #(
   parameter int unsigned WIDTH = 31
) ();
   logic             next;
   logic             seed_load;
   logic [WIDTH-1:0] seed_in;
   logic [WIDTH-1:0] value;
   logic             valid;
`ifdef RANDOM_LCG_DIST_EN
   logic [7:0]       dist;
   logic             layout_bit;
   logic             color_bit;

   modport master (
      output next, seed_load, seed_in,
      input  value, valid, dist, layout_bit, color_bit
   );
   modport slave (
      input  next, seed_load, seed_in,
      output value, valid, dist, layout_bit, color_bit
   );
`else
   modport master (
      output next, seed_load, seed_in,
      input  value, valid
   );
   modport slave (
      input  next, seed_load, seed_in,
      output value, valid
   );
`endif
endinterface

// File: rtl/random_lcg.sv
// 31-bit glibc-style LCG stepped once per 'next' cycle; seedable, restart-reproducible.
// Optional registered dist/layout/color outputs under RANDOM_LCG_DIST_EN.
module random_lcg #(
   parameter int unsigned WIDTH = 31,
   parameter int unsigned SEED  = 879387228,
   parameter int unsigned MULT  = 1103515245,
   parameter int unsigned INC   = 12345
) (
   input logic          clk,
   input logic          restart,
   random_lcg_if.slave  bus
);
   localparam logic [WIDTH-1:0] SeedW = WIDTH'(SEED);
   localparam logic [WIDTH-1:0] MultW = WIDTH'(MULT);
   localparam logic [WIDTH-1:0] IncW  = WIDTH'(INC);

   logic [WIDTH-1:0] state_q, state_d, step;
   logic             valid_q, valid_d;

   // Low WIDTH bits of the product only depend on the low WIDTH bits of the operands.
   always_comb step = state_q * MultW + IncW;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      if (bus.seed_load) begin
         state_d = bus.seed_in;
         valid_d = 1'b0;
      end else if (bus.next) begin
         state_d = step;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (restart) begin
         state_q <= SeedW;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

   assign bus.value = state_q;
   assign bus.valid = valid_q;

`ifdef RANDOM_LCG_DIST_EN
   logic [7:0] dist_q;
   logic       layout_q, color_q;

   // Decoded from the incoming state so they track value on the same edge.
   always_ff @(posedge clk) begin
      if (restart) begin
         dist_q   <= 8'd13 + {5'd0, SeedW[2:0]};
         layout_q <= SeedW[0];
         color_q  <= SeedW[1];
      end else begin
         dist_q   <= 8'd13 + {5'd0, state_d[2:0]};
         layout_q <= state_d[0];
         color_q  <= state_d[1];
      end
   end

   assign bus.dist       = dist_q;
   assign bus.layout_bit = layout_q;
   assign bus.color_bit  = color_q;
`endif
endmodule

// File: tb/tb_random_lcg.sv
// Self-checking bench for random_lcg: vector table plus hand-written sequences,
// expected outputs queued when stimulus is driven and popped after each edge.
module tb_random_lcg;
   localparam logic [30:0] Seed = 31'd879387228;

   typedef struct packed {
      logic [30:0] value;
      logic        valid;
   } exp_t;

   typedef struct {
      logic        restart;
      logic        seed_load;
      logic        next;
      logic [30:0] seed_in;
      logic [30:0] exp_value;
      logic        exp_valid;
   } vec_t;

   logic clk = 1'b0;
   logic restart;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   vec_t vecs[11];

   random_lcg_if #(.WIDTH(31)) lcg_bus ();

   random_lcg dut (
      .clk     (clk),
      .restart (restart),
      .bus     (lcg_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [30:0] lcg(input logic [30:0] s);
      logic [63:0] p;
      p = {33'd0, s} * 64'd1103515245 + 64'd12345;
      return p[30:0];
   endfunction

   task automatic cycle(input logic r, input logic sl, input logic nx,
                        input logic [30:0] si, input logic [30:0] ev, input logic evd,
                        input string name);
      exp_t e;
      exp_q.push_back('{value: ev, valid: evd});
      restart           = r;
      lcg_bus.seed_load = sl;
      lcg_bus.next      = nx;
      lcg_bus.seed_in   = si;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (lcg_bus.value !== e.value || lcg_bus.valid !== e.valid) begin
         failures++;
         $display("FAIL %s: got value=%0d valid=%0b, want value=%0d valid=%0b",
                  name, lcg_bus.value, lcg_bus.valid, e.value, e.valid);
      end
`ifdef RANDOM_LCG_DIST_EN
      checks++;
      if (lcg_bus.dist !== 8'd13 + {5'd0, e.value[2:0]} ||
          lcg_bus.layout_bit !== e.value[0] || lcg_bus.color_bit !== e.value[1]) begin
         failures++;
         $display("FAIL %s dist: got dist=%0d layout=%0b color=%0b, want dist=%0d layout=%0b color=%0b",
                  name, lcg_bus.dist, lcg_bus.layout_bit, lcg_bus.color_bit,
                  8'd13 + {5'd0, e.value[2:0]}, e.value[0], e.value[1]);
      end
`endif
   endtask

   initial begin
      logic [30:0] m;
      logic        prev_b0;

      //            rst   sl    nx    seed_in  value            valid
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 31'd0,  Seed,            1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 31'd0,  31'd711727461,   1'b1};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 31'd0,  31'd711727461,   1'b1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 31'd0,  31'd0,           1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 31'd0,  31'd12345,       1'b1};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 31'd1,  31'd1,           1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 31'd0,  31'd1103527590,  1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 31'd5,  Seed,            1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 31'd77, 31'd77,          1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 31'd0,  Seed,            1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 31'd0,  31'd711727461,   1'b1};

      restart           = 1'b1;
      lcg_bus.seed_load = 1'b0;
      lcg_bus.next      = 1'b0;
      lcg_bus.seed_in   = '0;

      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].restart, vecs[i].seed_load, vecs[i].next, vecs[i].seed_in,
               vecs[i].exp_value, vecs[i].exp_valid, $sformatf("vec%0d", i));
      end

      // Idle after a step: value and valid must hold.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 31'd0, 31'd711727461, 1'b1, $sformatf("hold%0d", i));
      end

      // Two restarts, each followed by 4 steps: both runs must follow the model from SEED.
      for (int run = 0; run < 2; run++) begin
         cycle(1'b1, 1'b0, 1'b1, 31'd0, Seed, 1'b0, $sformatf("restart_run%0d", run));
         m       = Seed;
         prev_b0 = lcg_bus.value[0];
         for (int i = 0; i < 4; i++) begin
            m = lcg(m);
            cycle(1'b0, 1'b0, 1'b1, 31'd0, m, 1'b1, $sformatf("seq_run%0d_step%0d", run, i));
            checks++;
            if (lcg_bus.value[0] === prev_b0) begin
               failures++;
               $display("FAIL bit0_alt run%0d step%0d: got bit0=%0b, want %0b",
                        run, i, lcg_bus.value[0], ~prev_b0);
            end
            prev_b0 = lcg_bus.value[0];
         end
      end

      // Seed 0 then a longer burst, compared step by step with the model.
      cycle(1'b0, 1'b1, 1'b0, 31'd0, 31'd0, 1'b0, "seed_zero");
      m = 31'd0;
      for (int i = 0; i < 6; i++) begin
         m = lcg(m);
         cycle(1'b0, 1'b0, 1'b1, 31'd0, m, 1'b1, $sformatf("burst%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
